fracdiv: RTL and testbench
==========================

FRACDIV -- requirements
Module: fracdiv

Interface
REQ-001 Parameter WI, default 3: integer bits of the average-ratio input.
REQ-002 Parameter WF, default 5: fractional bits of the average-ratio input.
REQ-003 Parameter MIN_RATIO, default 2: smallest divide ratio ever applied.
REQ-004 Ports:
- clk  in  1: single clock.
- rst  in  1: synchronous, active-high reset.
- en  in  1: count enable; low freezes all state.
- avgn  in  WI+WF: unsigned fixed point (WI,WF) average divide ratio, driven by the upstream low-pass filter.
- div_out  out  1: one-cycle pulse marking each divided-clock period.
- ratio  out  WI+1: integer ratio applied to the current period.

Function
REQ-005 Block SHALL divide clk by a time-varying integer ratio whose long-run mean equals avgn (first-order sigma-delta).
REQ-006 State SHALL be: down-counter cnt (WI+1 bits), fractional accumulator acc (WF bits), ratio register, div_out register.
REQ-007 A reload event SHALL occur on a clk edge where en=1 and cnt=0.
REQ-008 At reload, avgn SHALL be sampled; I=avgn[WI+WF-1:WF], F=avgn[WF-1:0].
REQ-009 At reload, sum = acc + F (WF+1 bits); acc <= sum[WF-1:0]; carry c = sum[WF].
REQ-010 Raw ratio r = I + c, computed in WI+1 bits without overflow (max 2^WI).
REQ-011 If r < MIN_RATIO, the applied ratio SHALL be MIN_RATIO; acc SHALL still update per REQ-009.
REQ-012 At reload: ratio <= applied ratio; cnt <= applied ratio - 1; div_out <= 1.
REQ-013 On a non-reload edge with en=1: cnt <= cnt - 1; div_out <= 0.
REQ-014 With en=0: cnt, acc and ratio SHALL hold; div_out <= 0.
REQ-015 div_out period SHALL equal the applied ratio exactly; pulses SHALL never be adjacent.
REQ-016 avgn changes between reloads SHALL have no effect until the next reload.
REQ-017 acc SHALL wrap modulo 2^WF.

Reset
REQ-018 With rst=1 at a clk edge: cnt=0, acc=0, ratio=0, div_out=0; rst overrides en.
REQ-019 First edge with rst=0 and en=1 SHALL be a reload (div_out high after it).
REQ-020 Reset mid-period SHALL abandon the period with no partial pulse.

Configuration
REQ-021 Macro FRACDIV_DITHER_EN:
- Defined: acc widens to WF+1 bits; sum = acc + {F,1'b0} + d, where d is bit 0 of a 9-bit maximal-length LFSR (seed 9'h1FF) stepped at each reload; carry is the bit above acc. Resulting mean bias is +1/2^(WF+2) ratio units, documented and accepted.
- Undefined: no LFSR logic; behaviour exactly per REQ-009.
- Reset SHALL restore the LFSR seed.

Structure
REQ-022 Package fracdiv_pkg SHALL hold WI/WF/MIN_RATIO defaults, the LFSR seed and tap constants, and the ratio type width.
REQ-023 Sub-module fracdiv_sdm SHALL contain the accumulator, carry, clamp and optional dither logic. The top level SHALL contain the counter and pulse logic.

Verification
REQ-024 avgn=8'h60 (3.0), en=1 after reset -> div_out every 3 clocks; ratio=3 constant.
REQ-025 avgn=8'h70 (3.5) -> ratio sequence 3,4,3,4...; pulse spacing alternates 3,4.
REQ-026 avgn=8'hFF (7.96875) -> per 32 reloads, exactly one ratio 7 (first) and 31 ratios 8; total 255 clocks.
REQ-027 avgn=8'h00 and 8'h20 -> ratio clamped to 2; div_out every 2 clocks.
REQ-028 avgn=8'h70, en low for 5 cycles mid-period -> period stretched by 5; no pulse while en low; sequence resumes unchanged.
REQ-029 rst asserted mid-period at cnt=2 -> next cycle all outputs 0; first edge after release pulses; ratio sequence restarts at 3. With FRACDIV_DITHER_EN defined, the mean ratio over 512 reloads is within 1/64 of avgn.

Source files
------------

// File: rtl/fracdiv_pkg.sv
// +----------------------------------------------------------------------------+
// | fracdiv_pkg: shared defaults, dither LFSR constants and the ratio type     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fracdiv_pkg;

    localparam int c_WI_DEFAULT        = 3;
    localparam int c_WF_DEFAULT        = 5;
    localparam int c_MIN_RATIO_DEFAULT = 2;

    // 9-bit maximal-length sequence, polynomial x^9 + x^5 + 1
    localparam int         c_LFSR_W    = 9;
    localparam logic [8:0] c_LFSR_SEED = 9'h1FF;
    localparam logic [8:0] c_LFSR_TAPS = 9'h110;

    localparam int c_RATIO_W = c_WI_DEFAULT + 1;
    typedef logic [c_RATIO_W-1:0] ratio_t;

    function automatic logic [c_LFSR_W-1:0] lfsr_next(input logic [c_LFSR_W-1:0] s);
        return {s[c_LFSR_W-2:0], ^(s & c_LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fracdiv_sdm.sv
// +----------------------------------------------------------------------------+
// | fracdiv_sdm: first-order sigma-delta ratio generator with min-ratio clamp  |
// | Optional LFSR dither when FRACDIV_DITHER_EN is defined.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fracdiv_sdm
    import fracdiv_pkg::*;
#(
    parameter int WI        = c_WI_DEFAULT,
    parameter int WF        = c_WF_DEFAULT,
    parameter int MIN_RATIO = c_MIN_RATIO_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WI+WF-1:0] avgn,
    output logic [WI:0]      ratio_next
);

    localparam logic [WI:0] c_MIN = (WI+1)'(MIN_RATIO);

    logic [WI-1:0] w_int;
    logic [WF-1:0] w_frac;
    logic          w_carry;
    logic [WI:0]   w_raw;

    assign w_int  = avgn[WI+WF-1:WF];
    assign w_frac = avgn[WF-1:0];

`ifdef FRACDIV_DITHER_EN
    // One extra accumulator LSB absorbs the dither bit; F is pre-scaled to match
    logic [WF:0]          r_acc;
    logic [c_LFSR_W-1:0]  r_lfsr;
    logic [WF+1:0]        w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, w_frac, 1'b0} + {{(WF+1){1'b0}}, r_lfsr[0]};
    assign w_carry = w_sum[WF+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_lfsr <= c_LFSR_SEED;
        end else if (load) begin
            r_acc  <= w_sum[WF:0];
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end
`else
    logic [WF-1:0] r_acc;
    logic [WF:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, w_frac};
    assign w_carry = w_sum[WF];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= w_sum[WF-1:0];
        end
    end
`endif

    assign w_raw      = {1'b0, w_int} + {{WI{1'b0}}, w_carry};
    assign ratio_next = (w_raw < c_MIN) ? c_MIN : w_raw;

endmodule

`default_nettype wire

// File: rtl/fracdiv.sv
// +----------------------------------------------------------------------------+
// | fracdiv: fractional clock divider, one-cycle pulse per divided period      |
// | FRACDIV_DITHER_EN enables LFSR dither inside fracdiv_sdm.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fracdiv
    import fracdiv_pkg::*;
#(
    parameter int WI        = c_WI_DEFAULT,
    parameter int WF        = c_WF_DEFAULT,
    parameter int MIN_RATIO = c_MIN_RATIO_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WI+WF-1:0] avgn,
    output logic             div_out,
    output logic [WI:0]      ratio
);

    logic [WI:0] r_cnt;
    logic [WI:0] r_ratio;
    logic        r_div;
    logic        w_reload;
    logic [WI:0] w_applied;

    assign w_reload = en && (r_cnt == '0);

    fracdiv_sdm #(
        .WI        (WI),
        .WF        (WF),
        .MIN_RATIO (MIN_RATIO)
    ) u_sdm (
        .clk        (clk),
        .rst        (rst),
        .load       (w_reload),
        .avgn       (avgn),
        .ratio_next (w_applied)
    );

    // cnt is zero out of reset, so the first enabled edge is always a reload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_ratio <= '0;
            r_div   <= 1'b0;
        end else if (en) begin
            if (w_reload) begin
                r_ratio <= w_applied;
                r_cnt   <= w_applied - (WI+1)'(1);
                r_div   <= 1'b1;
            end else begin
                r_cnt   <= r_cnt - (WI+1)'(1);
                r_div   <= 1'b0;
            end
        end else begin
            r_div <= 1'b0;
        end
    end

    assign div_out = r_div;
    assign ratio   = r_ratio;

endmodule

`default_nettype wire

// File: tb/tb_fracdiv.sv
// +----------------------------------------------------------------------------+
// | tb_fracdiv: scoreboard bench for fracdiv, random periods vs ratio model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fracdiv;

    localparam int WI        = 3;
    localparam int WF        = 5;
    localparam int MIN_RATIO = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    avgn;
    logic          div_out;
    logic [3:0]    ratio;

    always #5 clk = ~clk;

    fracdiv #(
        .WI        (WI),
        .WF        (WF),
        .MIN_RATIO (MIN_RATIO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .avgn    (avgn),
        .div_out (div_out),
        .ratio   (ratio)
    );

    typedef struct {
        int r;
        int gap;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_on = 1'b0;
    int     since = 0;
    longint rsum = 0;
    int     pcnt = 0;

    // Reference model: ratio = floor((phase + avgn) / 2^WF), phase keeps the remainder
    int         m_acc;
    bit         m_first;
    int         m_prev_r;
    int         m_prev_st;
    logic [8:0] m_lfsr;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_reload(input int a);
        int tot;
        int r;
`ifdef FRACDIV_DITHER_EN
        tot    = m_acc + 2 * a + int'(m_lfsr[0]);
        r      = tot / (1 << (WF + 1));
        m_acc  = tot % (1 << (WF + 1));
        m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
`else
        tot   = m_acc + a;
        r     = tot / (1 << WF);
        m_acc = tot % (1 << WF);
`endif
        if (r < MIN_RATIO) r = MIN_RATIO;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            since++;
            if (div_out === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("ratio", int'(ratio), e.r);
                    if (e.gap != 0) check("spacing", since, e.gap);
                end
                rsum += longint'(ratio);
                pcnt++;
                since = 0;
            end
        end
    end

    task automatic step(input logic en_v, input logic [7:0] a);
        en   = en_v;
        avgn = a;
        @(negedge clk);
    endtask

    // One divided period: optional stalls before the reload edge, the reload edge
    // with avgn=a, then the remaining edges with garbage avgn and optional stalls.
    task automatic do_period(input logic [7:0] a, input int stall_pct,
                             input int mid_stall, input bit cut);
        int   r;
        int   s;
        int   st;
        exp_t e;
        s = 0;
        while (stall_pct > 0 && s < 3 && int'($urandom_range(99)) < stall_pct) begin
            step(1'b0, a);
            s++;
        end
        r     = model_reload(int'(a));
        e.r   = r;
        e.gap = m_first ? 0 : m_prev_r + m_prev_st + s;
        q.push_back(e);
        m_first = 1'b0;
        step(1'b1, a);
        m_prev_r  = r;
        m_prev_st = 0;
        if (cut) return;
        st = 0;
        for (int j = 1; j < r; j++) begin
            if (j == 1) begin
                for (int k = 0; k < mid_stall; k++) begin
                    step(1'b0, 8'($urandom));
                    st++;
                end
            end
            while (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
                step(1'b0, 8'($urandom));
                st++;
            end
            step(1'b1, 8'($urandom));
        end
        m_prev_st = st;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        step(1'($urandom), 8'($urandom));
        check("rst_div_out", int'(div_out), 0);
        check("rst_ratio", int'(ratio), 0);
        for (int i = 1; i < cycles; i++) step(1'($urandom), 8'($urandom));
        rst       = 1'b0;
        m_acc     = 0;
        m_first   = 1'b1;
        m_lfsr    = 9'h1FF;
        m_prev_r  = 0;
        m_prev_st = 0;
        q.delete();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        avgn = 8'h60;
        @(negedge clk);
        do_reset(3);
        mon_on = 1'b1;

        for (int i = 0; i < 6; i++) do_period(8'h60, 0, 0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 8; i++) do_period(8'h70, 0, 0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 33; i++) do_period(8'hFF, 0, 0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 4; i++) do_period(8'h00, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) do_period(8'h20, 0, 0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 2; i++) do_period(8'h70, 0, 0, 1'b0);
        do_period(8'h70, 0, 5, 1'b0);
        for (int i = 0; i < 3; i++) do_period(8'h70, 0, 0, 1'b0);

        // Reset while cnt=2 inside a ratio-3 period
        do_reset(1);
        do_period(8'h70, 0, 0, 1'b1);
        do_reset(1);
        for (int i = 0; i < 4; i++) do_period(8'h70, 0, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(99) < 4) begin
                do_period(8'($urandom), 0, 0, 1'b1);
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                do_period(8'($urandom), 20, 0, 1'b0);
            end
        end

`ifdef FRACDIV_DITHER_EN
        begin
            longint s0;
            longint diff;
            int     p0;
            do_reset(2);
            step(1'b0, 8'h5B);
            s0 = rsum;
            p0 = pcnt;
            for (int i = 0; i < 512; i++) do_period(8'h5B, 0, 0, 1'b0);
            step(1'b0, 8'h5B);
            check("dither_pulses", pcnt - p0, 512);
            diff = (rsum - s0) * 32 - 512 * 64'h5B;
            if (diff < 0) diff = -diff;
            n_cmp++;
            if (diff * 64 > 512 * 32) begin
                n_bad++;
                $display("FAIL dither_mean: ratio sum %0d vs ideal %0d/32", rsum - s0, 512 * 'h5B);
            end
        end
`endif

        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
